// File: rtl/kasumi_mem_arbiter.sv
// rtl/kasumi_mem_arbiter.sv - single-port memory write arbiter between program loader and core stores
//
// Shares the integrated_mem write port between the external program loader
// and the core data-store path. One write strobe per transaction, then waits
// for the memory to finish. The loader is preferred, but it is limited to
// MAX_BURST consecutive grants while a core store is waiting. A memory that
// stays busy for TIMEOUT wait cycles sets a sticky error and the arbiter
// recovers to IDLE.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   ld_valid/ld_ready     loader write handshake; ld_addr/ld_data payload
//   core_wr_req           core store request, held until core_stall is seen low
//   core_funct3/addr/wdata core store size code, address and data
//   core_stall            freezes the core pipeline
//   mem_busy              memory write still in progress
//   mem_is_write          one-cycle write strobe per transaction
//   mem_funct3/addr/wdata registered transaction payload to memory
//   grant_src             source of current/last transaction (0 core, 1 loader)
//   err_timeout           sticky hung-memory flag, cleared only by reset

module kasumi_mem_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        core_wr_req,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  input  logic        mem_busy,
  output logic        mem_is_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        grant_src,
  output logic        err_timeout
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX   = BW'(MAX_BURST);
  // The timeout fires in the WAIT cycle whose busy sample makes the count reach TIMEOUT.
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [2:0]    FUNCT3_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] tmo_cnt;

  logic ld_ok;
  logic ld_win;
  logic core_win;
  logic timeout;
  logic core_done;
  logic ld_active;

  // Loader may go unless a core store waits and the loader has used its burst.
  assign ld_ok     = !core_wr_req || (burst_cnt < BURST_MAX);
  assign ld_win    = (state == ST_IDLE) && ld_valid && ld_ok;
  assign core_win  = (state == ST_IDLE) && core_wr_req && !ld_win;
  assign timeout   = (state == ST_WAIT) && mem_busy && (tmo_cnt == TMO_LAST);
  assign core_done = (state == ST_WAIT) && !grant_src && (!mem_busy || timeout);
  assign ld_active = (state != ST_IDLE) && grant_src;

  // Both combinational outputs are forced low while reset is held.
  assign ld_ready   = reset && (state == ST_IDLE) && ld_ok;
  assign core_stall = reset && (ld_valid || ld_active || (core_wr_req && !core_done));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      burst_cnt    <= '0;
      tmo_cnt      <= '0;
      mem_is_write <= 1'b0;
      mem_funct3   <= 3'b000;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      grant_src    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      mem_is_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_win) begin
            state        <= ST_ISSUE;
            mem_is_write <= 1'b1;
            mem_addr     <= ld_addr;
            mem_wdata    <= ld_data;
            mem_funct3   <= FUNCT3_WORD;
            grant_src    <= 1'b1;
            tmo_cnt      <= '0;
            // Only grants taken over a waiting core store count toward the burst.
            if (core_wr_req) begin
              if (burst_cnt != BURST_MAX) begin
                burst_cnt <= burst_cnt + 1'b1;
              end
            end else begin
              burst_cnt <= '0;
            end
          end else if (core_win) begin
            state        <= ST_ISSUE;
            mem_is_write <= 1'b1;
            mem_addr     <= core_addr;
            mem_wdata    <= core_wdata;
            mem_funct3   <= core_funct3;
            grant_src    <= 1'b0;
            tmo_cnt      <= '0;
            burst_cnt    <= '0;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!mem_busy) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kasumi_mem_arbiter.sv
// tb/tb_kasumi_mem_arbiter.sv - scoreboard bench for kasumi_mem_arbiter
module tb_kasumi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        core_wr_req;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        mem_busy;
  logic        mem_is_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        grant_src;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        src;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_t;

  kasumi_mem_arbiter #(.MAX_BURST(4), .TIMEOUT(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .core_wr_req (core_wr_req),
    .core_funct3 (core_funct3),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_stall  (core_stall),
    .mem_busy    (mem_busy),
    .mem_is_write(mem_is_write),
    .mem_funct3  (mem_funct3),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .grant_src   (grant_src),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic s);
    txn_t t;
    t.addr = a;
    t.data = d;
    t.f3   = f;
    t.src  = s;
    exp_q.push_back(t);
  endtask

  // Bounded wait for a pending core store to complete, then release the request.
  task automatic wait_stall_low(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_stall === 1'b0) break;
    end
    chk(name, 32'(core_stall), 32'd0);
    @(posedge clk);
    #1 core_wr_req = 1'b0;
  endtask

  // Monitor: every write strobe must match the next expected transaction.
  always @(negedge clk) begin
    if (mem_is_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h src %0d expected no write", mem_addr, grant_src);
      end else begin
        mon_t = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_t.addr);
        chk("wr_data", mem_wdata, mon_t.data);
        chk("wr_funct3", 32'(mem_funct3), 32'(mon_t.f3));
        chk("wr_src", 32'(grant_src), 32'(mon_t.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ld_valid = 1'b1; core_wr_req = 1'b1;
    ld_addr = 32'h1; ld_data = 32'h0;
    core_funct3 = 3'b000; core_addr = 32'h0; core_wdata = 32'h0;
    mem_busy = 1'b0;
    #12;
    chk("rst_is_write", 32'(mem_is_write), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_funct3", 32'(mem_funct3), 32'd0);
    chk("rst_grant_src", 32'(grant_src), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_core_stall", 32'(core_stall), 32'd0);
    ld_valid = 1'b0; core_wr_req = 1'b0; ld_addr = 32'h0;
    @(negedge clk) reset = 1'b1;

    // Single loader write
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h100; ld_data = 32'hDEADBEEF;
    push_exp(32'h100, 32'hDEADBEEF, 3'b010, 1'b1);
    @(negedge clk);
    chk("t1_ld_ready", 32'(ld_ready), 32'd1);
    chk("t1_stall_ldvalid", 32'(core_stall), 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    @(negedge clk);
    chk("t1_issue_stall", 32'(core_stall), 32'd1);
    chk("t1_issue_ld_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    chk("t1_wait_stall", 32'(core_stall), 32'd1);
    chk("t1_wait_ld_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    chk("t1_idle_ld_ready", 32'(ld_ready), 32'd1);
    chk("t1_idle_stall", 32'(core_stall), 32'd0);
    chk("t1_hold_addr", mem_addr, 32'h100);

    // Core store, memory busy for 3 WAIT cycles
    @(posedge clk); #1;
    core_wr_req = 1'b1; core_funct3 = 3'b000; core_addr = 32'h40; core_wdata = 32'h55AA00FF;
    mem_busy = 1'b1;
    push_exp(32'h40, 32'h55AA00FF, 3'b000, 1'b0);
    @(negedge clk);
    chk("t2_idle_stall", 32'(core_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_issue_stall", 32'(core_stall), 32'd1);
    chk("t2_issue_src", 32'(grant_src), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_busy_stall", 32'(core_stall), 32'd1);
      chk("t2_busy_src", 32'(grant_src), 32'd0);
    end
    @(posedge clk); #1 mem_busy = 1'b0;
    @(negedge clk);
    chk("t2_done_stall", 32'(core_stall), 32'd0);
    chk("t2_done_src", 32'(grant_src), 32'd0);
    @(posedge clk); #1 core_wr_req = 1'b0;
    @(negedge clk);
    chk("t2_after_stall", 32'(core_stall), 32'd0);

    // Fairness: both held, order L L L L C L L L L C
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h1000; ld_data = 32'hA5A5A5A5;
    core_wr_req = 1'b1; core_funct3 = 3'b001; core_addr = 32'h2000; core_wdata = 32'h12345678;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_exp(32'h1000, 32'hA5A5A5A5, 3'b010, 1'b1);
      push_exp(32'h2000, 32'h12345678, 3'b001, 1'b0);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("fair_ld_ready", 32'(ld_ready), ((c % 3 == 0) && c != 12 && c != 27) ? 32'd1 : 32'd0);
      @(posedge clk);
    end
    #1 ld_valid = 1'b0; core_wr_req = 1'b0;

    // Timeout: memory stays busy after a loader capture
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h300; ld_data = 32'hCAFEF00D; mem_busy = 1'b1;
    push_exp(32'h300, 32'hCAFEF00D, 3'b010, 1'b1);
    @(posedge clk); #1 ld_valid = 1'b0;
    repeat (255) @(posedge clk);
    @(negedge clk);
    chk("t4_err_before", 32'(err_timeout), 32'd0);
    chk("t4_still_wait", 32'(ld_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_err_set", 32'(err_timeout), 32'd1);
    chk("t4_back_idle", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    mem_busy = 1'b0;
    core_wr_req = 1'b1; core_funct3 = 3'b010; core_addr = 32'h500; core_wdata = 32'h0BADC0DE;
    push_exp(32'h500, 32'h0BADC0DE, 3'b010, 1'b0);
    wait_stall_low("t4_next_served");
    @(negedge clk);
    chk("t4_err_sticky", 32'(err_timeout), 32'd1);
    chk("t4_hold_addr", mem_addr, 32'h500);

    // Reset during ISSUE abandons the strobe at once
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h700; ld_data = 32'h11111111;
    @(posedge clk); #1 ld_valid = 1'b0;
    chk("t5_issue_strobe", 32'(mem_is_write), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_strobe", 32'(mem_is_write), 32'd0);
    chk("t5_rst_err", 32'(err_timeout), 32'd0);
    @(negedge clk) reset = 1'b1;

    // Reset mid-WAIT
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h600; ld_data = 32'h66666666; mem_busy = 1'b1;
    push_exp(32'h600, 32'h66666666, 3'b010, 1'b1);
    @(posedge clk); #1 ld_valid = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_strobe", 32'(mem_is_write), 32'd0);
    chk("t6_rst_funct3", 32'(mem_funct3), 32'd0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    chk("t6_rst_wdata", mem_wdata, 32'h0);
    chk("t6_rst_src", 32'(grant_src), 32'd0);
    chk("t6_rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("t6_rst_stall", 32'(core_stall), 32'd0);
    mem_busy = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    core_wr_req = 1'b1; core_funct3 = 3'b001; core_addr = 32'h800; core_wdata = 32'h00000088;
    push_exp(32'h800, 32'h00000088, 3'b001, 1'b0);
    wait_stall_low("t6_core_after_rst");
    @(negedge clk);
    chk("t6_post_src", 32'(grant_src), 32'd0);
    chk("t6_post_addr", mem_addr, 32'h800);
    chk("t6_idle_stall", 32'(core_stall), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
